// File: rtl/unpacker_if.sv
// Wide-word write side and narrow-slice read side of the unpacker.
// The slave modport is the unpacker itself; the master modport is the producer/consumer side.
interface unpacker_if #(
  parameter int PACKED_WIDTH   = 128,
  parameter int UNPACKED_WIDTH = 64
);
  localparam int NUM   = PACKED_WIDTH / UNPACKED_WIDTH;
  localparam int CNT_W = $clog2(NUM) + 1;

  logic                      Packed_EnWr;
  logic                      Packed_RdyWr;
  logic [PACKED_WIDTH-1:0]   Packed_DatWr;
  logic [CNT_W-1:0]          Packed_LenWr;
  logic                      Unpacked_RdyRd;
  logic                      Unpacked_EnRd;
  logic [UNPACKED_WIDTH-1:0] Unpacked_DatRd;
  logic                      Unpacked_LastRd;

  modport master (
    output Packed_EnWr, Packed_DatWr, Packed_LenWr, Unpacked_EnRd,
    input  Packed_RdyWr, Unpacked_RdyRd, Unpacked_DatRd, Unpacked_LastRd
  );

  modport slave (
    input  Packed_EnWr, Packed_DatWr, Packed_LenWr, Unpacked_EnRd,
    output Packed_RdyWr, Unpacked_RdyRd, Unpacked_DatRd, Unpacked_LastRd
  );
endinterface

// File: rtl/unpacker.sv
// Wide-to-narrow unpacker: two-entry wide buffer, emits each stored word
// most-significant slice first, one slice per read handshake.
module unpacker #(
  parameter int PACKED_WIDTH   = 128,
  parameter int UNPACKED_WIDTH = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Reset,
  unpacker_if.slave  bus
);
  localparam int NUM   = PACKED_WIDTH / UNPACKED_WIDTH;
  localparam int CNT_W = $clog2(NUM) + 1;

  if (NUM < 1 || PACKED_WIDTH != NUM * UNPACKED_WIDTH) begin : g_bad_cfg
    $error("unpacker: PACKED_WIDTH must be a positive integer multiple of UNPACKED_WIDTH");
  end

  logic [PACKED_WIDTH-1:0]   mem_dat [2];
  logic [CNT_W-1:0]          mem_len [2];
  logic                      head;
  logic                      tail;
  logic [1:0]                occ;
  logic [CNT_W-1:0]          cnt;

  logic                      wr_fire;
  logic                      rd_fire;
  logic                      rd_last;
  logic                      is_last;
  logic [CNT_W-1:0]          len_head;
  logic [UNPACKED_WIDTH-1:0] dat_sel;

  // Zero or an out-of-range length means a full word.
  function automatic logic [CNT_W-1:0] sat_len(input logic [CNT_W-1:0] len);
    if (len == '0 || len >= CNT_W'(NUM))
      return CNT_W'(NUM);
    return len;
  endfunction

  assign len_head = mem_len[head];
  assign is_last  = (cnt == len_head - CNT_W'(1));
  assign wr_fire  = bus.Packed_EnWr & (occ != 2'd2);
  assign rd_fire  = bus.Unpacked_EnRd & (occ != 2'd0);
  assign rd_last  = rd_fire & is_last;

  always_comb begin
    dat_sel = '0;
    for (int i = 0; i < NUM; i++) begin
      if (cnt == CNT_W'(i))
        dat_sel = mem_dat[head][PACKED_WIDTH-1-i*UNPACKED_WIDTH -: UNPACKED_WIDTH];
    end
  end

  assign bus.Packed_RdyWr    = (occ != 2'd2);
  assign bus.Unpacked_RdyRd  = (occ != 2'd0);
  assign bus.Unpacked_LastRd = (occ != 2'd0) & is_last;
  assign bus.Unpacked_DatRd  = dat_sel;

  // Control: occupancy, ring pointers and slice counter.
  always_ff @(posedge clk) begin
    if (!rst_n || Reset) begin
      occ  <= 2'd0;
      head <= 1'b0;
      tail <= 1'b0;
      cnt  <= '0;
    end else begin
      if (wr_fire)
        tail <= ~tail;
      if (rd_last)
        head <= ~head;
      if (rd_fire)
        cnt <= is_last ? '0 : cnt + CNT_W'(1);
      case ({wr_fire, rd_last})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage: hard reset clears the words, a soft flush only discards the write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        mem_dat[i] <= '0;
        mem_len[i] <= '0;
      end
    end else if (wr_fire && !Reset) begin
      mem_dat[tail] <= bus.Packed_DatWr;
      mem_len[tail] <= sat_len(bus.Packed_LenWr);
    end
  end
endmodule

// File: tb/tb_unpacker.sv
// Directed bench for unpacker: 128->32 instance for ordering, flow control,
// partial length and flush; 64->64 instance for passthrough.
module tb_unpacker;
  logic clk = 1'b0;
  logic rst_n;
  logic Reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  unpacker_if #(.PACKED_WIDTH(128), .UNPACKED_WIDTH(32)) bus_a ();
  unpacker_if #(.PACKED_WIDTH(64),  .UNPACKED_WIDTH(64)) bus_p ();

  unpacker #(.PACKED_WIDTH(128), .UNPACKED_WIDTH(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .Reset(Reset), .bus(bus_a.slave)
  );
  unpacker #(.PACKED_WIDTH(64), .UNPACKED_WIDTH(64)) dut_p (
    .clk(clk), .rst_n(rst_n), .Reset(Reset), .bus(bus_p.slave)
  );

  localparam logic [127:0] W_ABCD = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
  localparam logic [127:0] W_EFGH = {32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
  localparam logic [127:0] W_B1   = {32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004};
  localparam logic [127:0] W_B2   = {32'hB0000001, 32'hB0000002, 32'hB0000003, 32'hB0000004};
  localparam logic [127:0] W_B3   = {32'hC0000001, 32'hC0000002, 32'hC0000003, 32'hC0000004};

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_slice(input string tag, input logic [31:0] dat, input logic last);
    chk({tag, ".rdy"},  64'(bus_a.Unpacked_RdyRd),  64'(1));
    chk({tag, ".dat"},  64'(bus_a.Unpacked_DatRd),  64'(dat));
    chk({tag, ".last"}, 64'(bus_a.Unpacked_LastRd), 64'(last));
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, ".rdyrd"}, 64'(bus_a.Unpacked_RdyRd),  64'(0));
    chk({tag, ".last"},  64'(bus_a.Unpacked_LastRd), 64'(0));
    chk({tag, ".rdywr"}, 64'(bus_a.Packed_RdyWr),    64'(1));
  endtask

  logic [31:0] exp_seq [8];

  initial begin
    rst_n = 1'b0;
    Reset = 1'b0;
    bus_a.Packed_EnWr = 1'b0; bus_a.Packed_DatWr = '0; bus_a.Packed_LenWr = '0; bus_a.Unpacked_EnRd = 1'b0;
    bus_p.Packed_EnWr = 1'b0; bus_p.Packed_DatWr = '0; bus_p.Packed_LenWr = '0; bus_p.Unpacked_EnRd = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    chk_empty("rst");
    chk("rst.dat", 64'(bus_a.Unpacked_DatRd), 64'(0));
    chk("rst.p_rdyrd", 64'(bus_p.Unpacked_RdyRd), 64'(0));
    chk("rst.p_dat", bus_p.Unpacked_DatRd, 64'(0));

    // Basic order, read offered while empty is ignored
    bus_a.Packed_DatWr = W_ABCD; bus_a.Packed_LenWr = 3'd0;
    bus_a.Packed_EnWr = 1'b1; bus_a.Unpacked_EnRd = 1'b1;
    tick();
    bus_a.Packed_EnWr = 1'b0;
    chk_slice("basic0", 32'h11111111, 1'b0); tick();
    chk_slice("basic1", 32'h22222222, 1'b0); tick();
    chk_slice("basic2", 32'h33333333, 1'b0); tick();
    chk_slice("basic3", 32'h44444444, 1'b1); tick();
    chk_empty("basic_end");

    // Back-to-back until full, third word dropped
    bus_a.Unpacked_EnRd = 1'b0;
    bus_a.Packed_EnWr = 1'b1; bus_a.Packed_DatWr = W_B1;
    tick();
    chk("full.rdywr1", 64'(bus_a.Packed_RdyWr), 64'(1));
    bus_a.Packed_DatWr = W_B2;
    tick();
    chk("full.rdywr2", 64'(bus_a.Packed_RdyWr), 64'(0));
    bus_a.Packed_DatWr = W_B3;
    tick();
    chk("full.rdywr3", 64'(bus_a.Packed_RdyWr), 64'(0));
    bus_a.Packed_EnWr = 1'b0;
    bus_a.Unpacked_EnRd = 1'b1;
    exp_seq = '{32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004,
                32'hB0000001, 32'hB0000002, 32'hB0000003, 32'hB0000004};
    for (int i = 0; i < 8; i++) begin
      chk_slice($sformatf("b2b%0d", i), exp_seq[i], (i % 4) == 3);
      chk($sformatf("b2b%0d.rdywr", i), 64'(bus_a.Packed_RdyWr), 64'(i >= 4));
      tick();
    end
    chk_empty("b2b_end");

    // Partial length; length changed after capture must not matter
    bus_a.Packed_EnWr = 1'b1; bus_a.Packed_DatWr = W_ABCD; bus_a.Packed_LenWr = 3'd2;
    tick();
    bus_a.Packed_DatWr = W_EFGH; bus_a.Packed_LenWr = 3'd0;
    chk_slice("part0", 32'h11111111, 1'b0); tick();
    bus_a.Packed_EnWr = 1'b0;
    chk_slice("part1", 32'h22222222, 1'b1); tick();
    chk_slice("part2", 32'h55555555, 1'b0); tick();
    chk_slice("part3", 32'h66666666, 1'b0); tick();
    chk_slice("part4", 32'h77777777, 1'b0); tick();
    chk_slice("part5", 32'h88888888, 1'b1); tick();
    chk_empty("part_end");

    // Simultaneous last-slice read and write at occupancy 1
    bus_a.Packed_EnWr = 1'b1; bus_a.Packed_DatWr = W_ABCD;
    tick();
    bus_a.Packed_EnWr = 1'b0;
    chk_slice("sim0", 32'h11111111, 1'b0); tick();
    chk_slice("sim1", 32'h22222222, 1'b0); tick();
    chk_slice("sim2", 32'h33333333, 1'b0); tick();
    chk_slice("sim3", 32'h44444444, 1'b1);
    bus_a.Packed_EnWr = 1'b1; bus_a.Packed_DatWr = W_EFGH;
    tick();
    bus_a.Packed_EnWr = 1'b0;
    chk_slice("sim4", 32'h55555555, 1'b0);
    chk("sim4.rdywr", 64'(bus_a.Packed_RdyWr), 64'(1));
    tick();
    chk_slice("sim5", 32'h66666666, 1'b0); tick();
    chk_slice("sim6", 32'h77777777, 1'b0); tick();
    chk_slice("sim7", 32'h88888888, 1'b1); tick();
    chk_empty("sim_end");

    // Soft flush mid-word with a write offered
    bus_a.Packed_EnWr = 1'b1; bus_a.Packed_DatWr = W_ABCD;
    tick();
    bus_a.Packed_EnWr = 1'b0;
    chk_slice("fl0", 32'h11111111, 1'b0); tick();
    chk_slice("fl1", 32'h22222222, 1'b0); tick();
    Reset = 1'b1; bus_a.Packed_EnWr = 1'b1; bus_a.Packed_DatWr = W_EFGH;
    tick();
    Reset = 1'b0; bus_a.Packed_EnWr = 1'b0;
    chk_empty("flush");
    tick();
    chk_empty("flush_lost");
    bus_a.Packed_EnWr = 1'b1; bus_a.Packed_DatWr = W_B3; bus_a.Packed_LenWr = 3'd1;
    tick();
    bus_a.Packed_EnWr = 1'b0; bus_a.Packed_LenWr = 3'd0;
    chk_slice("flush_cnt0", 32'hC0000001, 1'b1); tick();
    chk_empty("flush_end");

    // Hard reset mid-word also clears the data
    bus_a.Packed_EnWr = 1'b1; bus_a.Packed_DatWr = W_ABCD;
    tick();
    bus_a.Packed_EnWr = 1'b0;
    chk_slice("hr0", 32'h11111111, 1'b0); tick();
    chk_slice("hr1", 32'h22222222, 1'b0); tick();
    rst_n = 1'b0; bus_a.Packed_EnWr = 1'b1; bus_a.Packed_DatWr = W_EFGH;
    tick();
    rst_n = 1'b1; bus_a.Packed_EnWr = 1'b0;
    chk_empty("hrst");
    chk("hrst.dat", 64'(bus_a.Unpacked_DatRd), 64'(0));
    bus_a.Unpacked_EnRd = 1'b0;

    // Passthrough with NUM==1: one word per cycle at occupancy 1
    bus_p.Packed_DatWr = 64'd1; bus_p.Packed_EnWr = 1'b1; bus_p.Unpacked_EnRd = 1'b1;
    tick();
    for (int k = 1; k <= 8; k++) begin
      bus_p.Packed_DatWr = 64'(k + 1);
      chk($sformatf("pt%0d.rdy", k),  64'(bus_p.Unpacked_RdyRd),  64'(1));
      chk($sformatf("pt%0d.dat", k),  bus_p.Unpacked_DatRd,       64'(k));
      chk($sformatf("pt%0d.last", k), 64'(bus_p.Unpacked_LastRd), 64'(1));
      chk($sformatf("pt%0d.rdywr", k), 64'(bus_p.Packed_RdyWr),   64'(1));
      tick();
    end
    bus_p.Packed_EnWr = 1'b0;
    chk("pt9.dat", bus_p.Unpacked_DatRd, 64'd9);
    tick();
    chk("pt_end.rdyrd", 64'(bus_p.Unpacked_RdyRd), 64'(0));
    bus_p.Unpacked_EnRd = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
